instr_fetch: RTL
================

Name: instr_fetch

Overview:
- PC register and instruction-fetch stage directly upstream of the main control decoder.
- Requests the instruction at PC from a variable-latency instruction memory and holds it stable while the core executes it.
- Drives opcode (instr[31:26]) to the control decoder.
- On the core's advance pulse, computes the next PC from the Branch, Jump and ALU-zero results and starts the next fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles to wait for imem_ack before faulting (must be >= 1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  byte address of the fetch; always equal to pc.
- imem_rdata  input  32  instruction word; valid only when imem_ack=1.
- imem_ack  input  1  memory response strobe.
- advance  input  1  core has finished the current instruction; pulse for 1 cycle.
- branch  input  1  Branch from the control decoder.
- jump  input  1  Jump from the control decoder.
- alu_zero  input  1  ALU zero flag for the current instruction.
- instr  output  32  held instruction word.
- instr_valid  output  1  instr and opcode are valid.
- opcode  output  6  instr[31:26], to the control decoder.
- pc  output  32  address of the held instruction.
- pc_plus4  output  32  pc + 4 (mod 2^32).
- fetch_fault  output  1  sticky imem timeout flag.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, instr=0, instr_valid=0, fetch_fault=0, imem_req=0.
  - wait counter=0, state=FETCH.
  - Reset mid-fetch aborts the fetch; any later ack for it is ignored because imem_req=0.
- States: FETCH, EXEC, HALT.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, state<=EXEC, counter<=0.
  - A same-cycle ack is legal: req in cycle N, ack in N, instr_valid=1 in N+1.
  - Without ack: counter increments. If counter==TIMEOUT-1 and no ack, then fetch_fault<=1 and state<=HALT.
- EXEC:
  - imem_req=0; instr_valid=1; instr, opcode and pc stay stable.
  - On advance=1: pc<=next_pc, instr_valid<=0, state<=FETCH.
  - branch, jump and alu_zero are sampled only in the cycle where advance=1; their values at any other time are don't-care.
- HALT:
  - imem_req=0, instr_valid=0; advance and imem_ack are ignored.
  - Exit only via reset.
- advance while in FETCH or HALT is ignored. imem_ack while imem_req=0 is ignored.
- next_pc, in priority order:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. Jump wins over branch.
  - branch=1 and alu_zero=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - Otherwise: pc_plus4.
- All PC arithmetic is 32-bit modulo 2^32; pc=32'hFFFF_FFFC wraps to 0. pc[1:0] is always 2'b00.
- Minimum throughput is one instruction per 2 cycles (zero-wait memory with advance asserted the first cycle of EXEC).

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (FETCH, EXEC, HALT);
  - opcode constants OP_RTYPE=6'b000100, OP_ADDIU=6'b001100, OP_SUBIU=6'b001101, OP_SW=6'b010000, OP_LW=6'b010001, OP_BEQ=6'b010011, OP_J=6'b011100, for bench instruction generation;
  - the default RESET_PC.
- One combinational sub-module, npc_calc: inputs pc_plus4, instr, branch, jump, alu_zero; output next_pc.

Test Plan:
- Reset then zero-wait memory:
  - Stimulus: rst_n released; imem_ack driven the same cycle as imem_req.
  - Response: imem_addr=0 first; instr_valid=1 one cycle later; opcode=instr[31:26]; advance gives pc=4.
- Sequential with latency:
  - Stimulus: ack delayed 3 cycles on each fetch.
  - Response: imem_addr stays stable through the wait; addresses 0, 4, 8 are fetched in order; instr_valid never rises before ack.
- Branch taken and not taken:
  - Stimulus: pc=0x100, instr imm=16'hFFFE, branch=1.
  - Response: with alu_zero=1, next pc=0x0FC; with alu_zero=0, next pc=0x104.
- Jump priority:
  - Stimulus: pc=0x1000_0000, instr[25:0]=26'h0000040, jump=1 and branch=1 with alu_zero=1.
  - Response: next pc=0x1000_0100.
- Timeout:
  - Stimulus: TIMEOUT=16; ack withheld for 16 cycles.
  - Response: fetch_fault=1 and imem_req=0; later acks and advance are ignored; rst_n low clears fault and pc=RESET_PC.
- Wrap and async reset:
  - Stimulus: pc=0xFFFF_FFFC, non-branch instr, advance.
  - Response: pc=0.
  - Stimulus: rst_n asserted mid-FETCH, between clock edges.
  - Response: instr_valid=0 and imem_req=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// fetch_pkg : shared states, opcode constants and reset PC for instr_fetch.
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001100;
    localparam logic [5:0] OP_SUBIU = 6'b001101;
    localparam logic [5:0] OP_SW    = 6'b010000;
    localparam logic [5:0] OP_LW    = 6'b010001;
    localparam logic [5:0] OP_BEQ   = 6'b010011;
    localparam logic [5:0] OP_J     = 6'b011100;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/npc_calc.sv
//------------------------------------------------------------------------------
// npc_calc : next-PC selection (jump > taken branch > sequential).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module npc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        alu_zero,
    output logic [31:0] next_pc
);

    logic [31:0] jump_target;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;

    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_offset;

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && alu_zero) begin
            next_pc = branch_target;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
//------------------------------------------------------------------------------
// instr_fetch : PC register and fetch stage with variable-latency imem and timeout.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        advance,
    input  logic        branch,
    input  logic        jump,
    input  logic        alu_zero,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_fault
);

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]     PC_INIT  = {RESET_PC[31:2], 2'b00};

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             req;
    logic             capture;
    logic             take_next;
    logic             fault_set;
    logic [31:0]      next_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req       = 1'b0;
        capture   = 1'b0;
        take_next = 1'b0;
        fault_set = 1'b0;
        case (state)
            FETCH: begin
                req = 1'b1;
                if (imem_ack) begin
                    capture   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = EXEC;
                end else if (cnt == CNT_LAST) begin
                    fault_set = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = HALT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            EXEC: begin
                if (advance) begin
                    take_next = 1'b1;
                    state_nxt = FETCH;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= PC_INIT;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            cnt         <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (capture) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (take_next) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
            end
            if (fault_set) begin
                fetch_fault <= 1'b1;
            end
        end
    end

    // Gate with rst_n so the request drops the instant reset asserts, not at the next edge.
    assign imem_req  = req & rst_n;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign opcode    = instr[31:26];

    npc_calc u_npc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .branch   (branch),
        .jump     (jump),
        .alu_zero (alu_zero),
        .next_pc  (next_pc)
    );

endmodule

`default_nettype wire
